stdout_tx_arbiter: RTL and testbench

Shares the single UART byte transmitter between two requesters: the CPU `stdout`/`stdout_en` byte stream and a debug/trace byte source. CPU bytes are buffered in a small FIFO so the core only stalls when the buffer is full. A round-robin scheduler grants one source per byte and sequences the transmitter's start/busy handshake. The block sits between the CPU core and the UART TX inside the top-level `verifuck` design.

---
 rtl/stdout_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_stdout_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_tx_arbiter.sv
// -----------------------------------------------------------------------------
// stdout_tx_arbiter
//
// Shares one UART byte transmitter between the CPU stdout byte stream and a
// debug/trace byte source. CPU bytes land in a small FIFO so the core only
// stalls when that buffer is full. A round-robin scheduler picks one source
// per byte, then walks the transmitter through its start/busy handshake.
//
// Build option:
//   STDOUT_TX_ARB_DBG_EN  defined   -> debug source + round-robin arbitration.
//                         undefined -> debug inputs ignored, CPU is the only
//                                      requester, dbg_ready/grant_dbg stay 0.
//
// Parameters:
//   CPU_FIFO_DEPTH  CPU byte FIFO depth (power of two, >= 2)
//   BUSY_TIMEOUT    cycles to wait for tx_busy after a start pulse (1..255)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   resetn        asynchronous active-low reset
//   cpu_data      CPU output byte
//   cpu_valid     one-cycle push strobe for cpu_data
//   cpu_stall     FIFO full; CPU must hold its next byte
//   cpu_overflow  sticky: a push arrived while full and was dropped
//   dbg_data      debug byte
//   dbg_valid     debug byte pending, held until accepted
//   dbg_ready     debug byte accepted this cycle (with dbg_valid)
//   tx_data       byte to the transmitter, stable for the whole transfer
//   tx_start      one-cycle start pulse to the transmitter
//   tx_busy       transmitter busy
//   grant_dbg     the current/last byte came from the debug source
// -----------------------------------------------------------------------------
module stdout_tx_arbiter #(
    parameter int CPU_FIFO_DEPTH = 4,
    parameter int BUSY_TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] cpu_data,
    input  logic       cpu_valid,
    output logic       cpu_stall,
    output logic       cpu_overflow,
    input  logic [7:0] dbg_data,
    input  logic       dbg_valid,
    output logic       dbg_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       grant_dbg
);

    localparam int               PTR_W        = $clog2(CPU_FIFO_DEPTH);
    localparam int               CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(CPU_FIFO_DEPTH);
    localparam logic [7:0]       TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       fifo_mem [CPU_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       timer;
    logic             last_dbg;

    logic             cpu_req;
    logic             dbg_req;
    logic             grant;
    logic             sel_dbg;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic [7:0]       grant_byte;

    assign fifo_full = (count == FULL_COUNT);
    assign cpu_stall = fifo_full;
    assign cpu_req   = (count != '0);

`ifdef STDOUT_TX_ARB_DBG_EN
    assign dbg_req = dbg_valid;
`else
    // Debug inputs are intentionally left unconnected in this build.
    logic unused_dbg;
    assign unused_dbg = ^{dbg_data, dbg_valid};
    assign dbg_req    = 1'b0;
`endif

    // Arbitration only happens in IDLE. On a tie the source that lost last
    // time wins; last_dbg resets to 1 so the CPU takes the first tie.
    always_comb begin
        grant   = 1'b0;
        sel_dbg = 1'b0;
        if (state == IDLE) begin
            grant   = cpu_req | dbg_req;
            sel_dbg = (cpu_req & dbg_req) ? ~last_dbg : dbg_req;
        end
    end

    assign pop       = grant & ~sel_dbg;
    assign dbg_ready = grant & sel_dbg;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push      = cpu_valid & (~fifo_full | pop);

    always_comb begin
        grant_byte = fifo_mem[rd_ptr];
`ifdef STDOUT_TX_ARB_DBG_EN
        if (sel_dbg) begin
            grant_byte = dbg_data;
        end
`endif
    end

    // FIFO storage: no reset, contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            cpu_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (cpu_valid && !push) begin
                cpu_overflow <= 1'b1;
            end
        end
    end

    // Transmit sequencer. tx_start is registered and high exactly while the
    // FSM sits in START.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            grant_dbg <= 1'b0;
            last_dbg  <= 1'b1;
            timer     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        tx_data   <= grant_byte;
                        grant_dbg <= sel_dbg;
                        last_dbg  <= sel_dbg;
                        tx_start  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    timer    <= 8'h00;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A transmitter that never answers must not lock the
                    // stream; after the timeout the byte is treated as sent.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMEOUT_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 8'h01;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stdout_tx_arbiter
//
// Directed bench for stdout_tx_arbiter. Stimulus pushes expected transmitter
// bytes ({grant_dbg, tx_data}) into a queue; a monitor pops and compares on
// every tx_start. A simple UART model raises tx_busy one cycle after a start
// for busy_len cycles, or never when never_busy is set.
// -----------------------------------------------------------------------------
module tb_stdout_tx_arbiter;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] cpu_data;
    logic       cpu_valid;
    logic       cpu_stall;
    logic       cpu_overflow;
    logic [7:0] dbg_data;
    logic       dbg_valid;
    logic       dbg_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       grant_dbg;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         start_count = 0;
    logic [8:0] exp_q[$];
    int         start_cyc_q[$];

    int         busy_len   = 3;
    bit         never_busy = 1'b0;
    int         busy_cnt   = 0;

    always #5 clk = ~clk;

    stdout_tx_arbiter #(
        .CPU_FIFO_DEPTH(DEPTH),
        .BUSY_TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_data    (cpu_data),
        .cpu_valid   (cpu_valid),
        .cpu_stall   (cpu_stall),
        .cpu_overflow(cpu_overflow),
        .dbg_data    (dbg_data),
        .dbg_valid   (dbg_valid),
        .dbg_ready   (dbg_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_dbg   (grant_dbg)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start && !never_busy) begin
            tx_busy  <= 1'b1;
            busy_cnt <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_busy  <= 1'b0;
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [8:0] exp_v;
        forever begin
            @(negedge clk);
            if (resetn && tx_start) begin
                start_count++;
                start_cyc_q.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_start: got dbg=%0b data=%02h, no byte expected",
                             grant_dbg, tx_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({grant_dbg, tx_data} !== exp_v) begin
                        bad++;
                        $display("FAIL tx_byte: got dbg=%0b data=%02h, want dbg=%0b data=%02h",
                                 grant_dbg, tx_data, exp_v[8], exp_v[7:0]);
                    end else begin
                        $display("tx byte dbg=%0b data=%02h at cycle %0d", grant_dbg, tx_data, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the strobe dropped.
    task automatic push(input logic [7:0] d);
        cpu_data  = d;
        cpu_valid = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        dbg_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_dbg(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (dbg_ready) got = 1'b1;
            @(negedge clk);
        end
        check(name, got, 1);
    endtask

    initial begin
        int sc;
        bit seen;
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        cpu_data  = 8'h00;
        dbg_valid = 1'b0;
        dbg_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_cpu_overflow", cpu_overflow, 0);
        check("rst_grant_dbg", grant_dbg, 0);
        check("rst_dbg_ready", dbg_ready, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Two consecutive CPU bytes, busy 3 cycles each: start period 6.
        busy_len = 3;
        start_cyc_q.delete();
        exp_q.push_back({1'b0, 8'h48});
        exp_q.push_back({1'b0, 8'h69});
        push(8'h48);
        push(8'h69);
        check("t1_stall", cpu_stall, 0);
        drain("t1_drain", 100);
        check("t1_starts", start_cyc_q.size(), 2);
        if (start_cyc_q.size() >= 2)
            check("t1_period", start_cyc_q[1] - start_cyc_q[0], 6);
        check("t1_overflow", cpu_overflow, 0);

        // Fill while the transmitter is busy: 4 accepted, 2 dropped.
        busy_len = 40;
        exp_q.push_back({1'b0, 8'h30});
        push(8'h30);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back({1'b0, 8'(8'h31 + i)});
            push(8'(8'h31 + i));
            if (i == 2) check("t2_stall_after3", cpu_stall, 0);
            if (i == 3) check("t2_stall_after4", cpu_stall, 1);
        end
        check("t2_overflow", cpu_overflow, 1);
        check("t2_stall_full", cpu_stall, 1);
        drain("t2_drain", 600);
        check("t2_stall_empty", cpu_stall, 0);
        check("t2_overflow_sticky", cpu_overflow, 1);

        // Transmitter never answers: timeout gives a start period of 17.
        never_busy = 1'b1;
        start_cyc_q.delete();
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'h56});
        push(8'h55);
        push(8'h56);
        drain("t4_drain", 100);
        check("t4_starts", start_cyc_q.size(), 2);
        if (start_cyc_q.size() >= 2)
            check("t4_timeout_period", start_cyc_q[1] - start_cyc_q[0], TMO + 2);
        never_busy = 1'b0;

        // Reset during WAIT_DONE with the FIFO full behind the byte in flight.
        busy_len = 30;
        exp_q.push_back({1'b0, 8'h70});
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        check("t5_stall_before", cpu_stall, 1);
        resetn = 1'b0;
        #1;
        check("t5_tx_start_rst", tx_start, 0);
        check("t5_stall_rst", cpu_stall, 0);
        check("t5_tx_data_rst", tx_data, 0);
        check("t5_overflow_rst", cpu_overflow, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sc = start_count;
        repeat (30) @(negedge clk);
        check("t5_no_start", start_count - sc, 0);
        exp_q.push_back({1'b0, 8'h7A});
        push(8'h7A);
        drain("t5_drain", 100);

        do_reset();

`ifdef STDOUT_TX_ARB_DBG_EN
        // Round robin: CPU wins the first tie after reset.
        busy_len = 1;
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b1, 8'hD0});
        exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b1, 8'hD1});
        push(8'h41);
        cpu_data  = 8'h42;
        cpu_valid = 1'b1;
        dbg_data  = 8'hD0;
        dbg_valid = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
        wait_dbg("t3_dbg_accept_d0");
        dbg_data = 8'hD1;
        wait_dbg("t3_dbg_accept_d1");
        dbg_valid = 1'b0;
        drain("t3_drain", 200);
`else
        // Debug source absent: a held request is never served.
        dbg_data  = 8'hEE;
        dbg_valid = 1'b1;
        sc   = start_count;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (dbg_ready) seen = 1'b1;
        end
        check("t6_dbg_ready", seen, 0);
        check("t6_no_start", start_count - sc, 0);
        check("t6_grant_dbg", grant_dbg, 0);
        dbg_valid = 1'b0;
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
